// File: rtl/regfile_ckpt_pkg.sv
// Shared widths, types and constants for the register file / rename table with branch checkpoints.
package regfile_ckpt_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_W     = 5;
    localparam int XLEN      = 32;
    localparam int ROB_W     = 4;
    localparam int NUM_RD    = 2;
    localparam int NUM_CKPT  = 4;
    localparam int CKPT_W    = 2;

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [ROB_W-1:0]  rob_tag_t;
    typedef logic [XLEN-1:0]   xdata_t;
    typedef logic [CKPT_W-1:0] ckpt_id_t;
    typedef logic [CKPT_W:0]   ckpt_cnt_t;

    // Tag 0 means "no producer"; register 0 is hardwired to zero.
    localparam rob_tag_t TAG_NONE = '0;
    localparam reg_idx_t REG_X0   = '0;

endpackage

// File: rtl/regfile_ckpt_if.sv
// Dispatcher / branch unit / ROB side of the register file, bundled as one interface.
interface regfile_ckpt_if;
    import regfile_ckpt_pkg::*;

    logic                      rdy_in;
    logic [NUM_RD*REG_W-1:0]   rd_addr_in;
    logic [NUM_RD-1:0]         rd_busy_out;
    logic [NUM_RD*XLEN-1:0]    rd_value_out;
    logic [NUM_RD*ROB_W-1:0]   rd_reorder_out;
    logic                      rename_en_in;
    reg_idx_t                  rename_rd_in;
    rob_tag_t                  rename_reorder_in;
    logic                      ckpt_save_en_in;
    logic                      ckpt_full_out;
    ckpt_id_t                  ckpt_save_id_out;
    logic                      ckpt_restore_en_in;
    ckpt_id_t                  ckpt_restore_id_in;
    logic                      ckpt_release_en_in;
    logic                      commit_en_in;
    reg_idx_t                  commit_rd_in;
    xdata_t                    commit_value_in;
    rob_tag_t                  commit_tag_in;
    logic                      flush_in;

    modport master (
        output rdy_in, rd_addr_in, rename_en_in, rename_rd_in, rename_reorder_in,
               ckpt_save_en_in, ckpt_restore_en_in, ckpt_restore_id_in, ckpt_release_en_in,
               commit_en_in, commit_rd_in, commit_value_in, commit_tag_in, flush_in,
        input  rd_busy_out, rd_value_out, rd_reorder_out, ckpt_full_out, ckpt_save_id_out
    );

    modport slave (
        input  rdy_in, rd_addr_in, rename_en_in, rename_rd_in, rename_reorder_in,
               ckpt_save_en_in, ckpt_restore_en_in, ckpt_restore_id_in, ckpt_release_en_in,
               commit_en_in, commit_rd_in, commit_value_in, commit_tag_in, flush_in,
        output rd_busy_out, rd_value_out, rd_reorder_out, ckpt_full_out, ckpt_save_id_out
    );

endinterface

// File: rtl/regfile_ckpt_queue.sv
// Circular checkpoint queue bookkeeping: head/tail/count, full flag, restore window check.
module regfile_ckpt_queue
    import regfile_ckpt_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_n_i,
    input  logic     rdy_i,
    input  logic     save_en_i,
    input  logic     release_en_i,
    input  logic     restore_en_i,
    input  ckpt_id_t restore_id_i,
    input  logic     flush_i,
    output ckpt_id_t tail_o,
    output logic     full_o,
    output logic     save_ok_o,
    output logic     restore_ok_o
);

    localparam ckpt_cnt_t FULL_CNT = ckpt_cnt_t'(NUM_CKPT);

    ckpt_id_t  head_q, head_d, tail_q, tail_d;
    ckpt_cnt_t count_q, count_d;
    ckpt_id_t  restore_off;

    // Distance of the restore slot from head; in-window when below the live count.
    assign restore_off  = restore_id_i - head_q;
    assign full_o       = (count_q == FULL_CNT);
    assign restore_ok_o = rdy_i && restore_en_i && !flush_i && ({1'b0, restore_off} < count_q);
    assign save_ok_o    = rdy_i && save_en_i && !full_o && !flush_i && !restore_ok_o;
    assign tail_o       = tail_q;

    // Next pointers: flush empties, restore truncates to the slot, otherwise save/release.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (restore_ok_o) begin
            tail_d  = restore_id_i;
            count_d = {1'b0, restore_off};
            if (release_en_i && (restore_off != '0)) begin
                head_d  = head_q + 1'b1;
                count_d = count_d - 1'b1;
            end
        end else begin
            if (release_en_i && (count_q != '0)) begin
                head_d  = head_q + 1'b1;
                count_d = count_d - 1'b1;
            end
            if (save_ok_o) begin
                tail_d  = tail_q + 1'b1;
                count_d = count_d + 1'b1;
            end
        end
    end

    // Pointer registers; reset wins over the stall.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_i) begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/regfile_ckpt.sv
// Architectural register file with rename table (busy, ROB tag) and branch checkpoints.
module regfile_ckpt
    import regfile_ckpt_pkg::*;
(
    input  logic           clk_in,
    input  logic           rst_n_in,
    regfile_ckpt_if.slave  bus
);

    xdata_t                 val_q   [REG_COUNT];
    xdata_t                 val_d   [REG_COUNT];
    logic [REG_COUNT-1:0]   busy_q, busy_d;
    rob_tag_t               tag_q   [REG_COUNT];
    rob_tag_t               tag_d   [REG_COUNT];
    logic [REG_COUNT-1:0]   sbusy_q [NUM_CKPT];
    logic [REG_COUNT-1:0]   sbusy_d [NUM_CKPT];
    rob_tag_t               stag_q  [NUM_CKPT][REG_COUNT];
    rob_tag_t               stag_d  [NUM_CKPT][REG_COUNT];

    ckpt_id_t tail;
    logic     save_ok, restore_ok;
    logic     commit_ok, live_match, rename_ok;

    regfile_ckpt_queue u_queue (
        .clk_i        (clk_in),
        .rst_n_i      (rst_n_in),
        .rdy_i        (bus.rdy_in),
        .save_en_i    (bus.ckpt_save_en_in),
        .release_en_i (bus.ckpt_release_en_in),
        .restore_en_i (bus.ckpt_restore_en_in),
        .restore_id_i (bus.ckpt_restore_id_in),
        .flush_i      (bus.flush_in),
        .tail_o       (tail),
        .full_o       (bus.ckpt_full_out),
        .save_ok_o    (save_ok),
        .restore_ok_o (restore_ok)
    );

    assign bus.ckpt_save_id_out = tail;
    assign commit_ok  = bus.commit_en_in && (bus.commit_rd_in != REG_X0);
    assign live_match = commit_ok && (tag_q[bus.commit_rd_in] == bus.commit_tag_in);
    assign rename_ok  = bus.rename_en_in && (bus.rename_rd_in != REG_X0);

    // Next-state tables: commit clears first (live and every snapshot), then flush/restore/rename/save.
    always_comb begin
        val_d   = val_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        sbusy_d = sbusy_q;
        stag_d  = stag_q;
        if (commit_ok) begin
            val_d[bus.commit_rd_in] = bus.commit_value_in;
        end
        for (int s = 0; s < NUM_CKPT; s++) begin
            if (commit_ok && (stag_q[s][bus.commit_rd_in] == bus.commit_tag_in)) begin
                sbusy_d[s][bus.commit_rd_in] = 1'b0;
                stag_d[s][bus.commit_rd_in]  = TAG_NONE;
            end
        end
        if (bus.flush_in) begin
            busy_d = '0;
            for (int r = 0; r < REG_COUNT; r++) tag_d[r] = TAG_NONE;
        end else if (restore_ok) begin
            busy_d = sbusy_d[bus.ckpt_restore_id_in];
            tag_d  = stag_d[bus.ckpt_restore_id_in];
        end else begin
            if (live_match) begin
                busy_d[bus.commit_rd_in] = 1'b0;
                tag_d[bus.commit_rd_in]  = TAG_NONE;
            end
            if (rename_ok) begin
                busy_d[bus.rename_rd_in] = 1'b1;
                tag_d[bus.rename_rd_in]  = bus.rename_reorder_in;
            end
            if (save_ok) begin
                sbusy_d[tail] = busy_d;
                stag_d[tail]  = tag_d;
            end
        end
    end

    // Table registers; everything clears on reset, holds while not ready.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            busy_q <= '0;
            for (int r = 0; r < REG_COUNT; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= TAG_NONE;
            end
            for (int s = 0; s < NUM_CKPT; s++) begin
                sbusy_q[s] <= '0;
                for (int r = 0; r < REG_COUNT; r++) stag_q[s][r] <= TAG_NONE;
            end
        end else if (bus.rdy_in) begin
            val_q   <= val_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
            sbusy_q <= sbusy_d;
            stag_q  <= stag_d;
        end
    end

    // Read ports: x0 reads idle zero; a matching commit this cycle bypasses to ready.
    always_comb begin
        bus.rd_busy_out    = '0;
        bus.rd_value_out   = '0;
        bus.rd_reorder_out = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rd_addr_in[p*REG_W +: REG_W] != REG_X0) begin
                if (bus.commit_en_in &&
                    (bus.commit_rd_in == bus.rd_addr_in[p*REG_W +: REG_W]) &&
                    (bus.commit_tag_in == tag_q[bus.rd_addr_in[p*REG_W +: REG_W]])) begin
                    bus.rd_value_out[p*XLEN +: XLEN] = bus.commit_value_in;
                end else begin
                    bus.rd_busy_out[p]                 = busy_q[bus.rd_addr_in[p*REG_W +: REG_W]];
                    bus.rd_value_out[p*XLEN +: XLEN]   = val_q[bus.rd_addr_in[p*REG_W +: REG_W]];
                    bus.rd_reorder_out[p*ROB_W +: ROB_W] = tag_q[bus.rd_addr_in[p*REG_W +: REG_W]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_ckpt.sv
// Randomised and directed bench for regfile_ckpt against a table-level reference model.
module tb_regfile_ckpt;
    import regfile_ckpt_pkg::*;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    always #5 clk_in = ~clk_in;

    regfile_ckpt_if bus ();
    regfile_ckpt dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: plain arrays plus queue pointers.
    logic [31:0] m_val [32];
    int m_busy [32];
    int m_tag  [32];
    int m_sb   [4][32];
    int m_st   [4][32];
    int m_head, m_tail, m_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_val[r] = '0; m_busy[r] = 0; m_tag[r] = 0;
            for (int s = 0; s < 4; s++) begin m_sb[s][r] = 0; m_st[s][r] = 0; end
        end
        m_head = 0; m_tail = 0; m_count = 0;
    endtask

    task automatic model_tick();
        int crd, ctag, off, id;
        bit c, rel_ok, save_ok;
        if (!rst_n_in) begin model_reset(); return; end
        if (!bus.rdy_in) return;
        crd  = int'(bus.commit_rd_in);
        ctag = int'(bus.commit_tag_in);
        id   = int'(bus.ckpt_restore_id_in);
        c    = bus.commit_en_in && crd != 0;
        rel_ok  = bus.ckpt_release_en_in && m_count != 0;
        save_ok = bus.ckpt_save_en_in && m_count < 4;
        if (c) begin
            m_val[crd] = bus.commit_value_in;
            for (int s = 0; s < 4; s++)
                if (m_st[s][crd] == ctag) begin m_sb[s][crd] = 0; m_st[s][crd] = 0; end
        end
        off = (id - m_head + 4) % 4;
        if (bus.flush_in) begin
            for (int r = 0; r < 32; r++) begin m_busy[r] = 0; m_tag[r] = 0; end
            m_head = 0; m_tail = 0; m_count = 0;
        end else if (bus.ckpt_restore_en_in && off < m_count) begin
            for (int r = 0; r < 32; r++) begin m_busy[r] = m_sb[id][r]; m_tag[r] = m_st[id][r]; end
            m_tail = id; m_count = off;
            if (bus.ckpt_release_en_in && m_count > 0) begin m_head = (m_head + 1) % 4; m_count--; end
        end else begin
            if (c && m_tag[crd] == ctag) begin m_busy[crd] = 0; m_tag[crd] = 0; end
            if (bus.rename_en_in && bus.rename_rd_in != 0) begin
                m_busy[bus.rename_rd_in] = 1; m_tag[bus.rename_rd_in] = int'(bus.rename_reorder_in);
            end
            if (rel_ok) begin m_head = (m_head + 1) % 4; m_count--; end
            if (save_ok) begin
                for (int r = 0; r < 32; r++) begin m_sb[m_tail][r] = m_busy[r]; m_st[m_tail][r] = m_tag[r]; end
                m_tail = (m_tail + 1) % 4; m_count++;
            end
        end
    endtask

    task automatic cmp_model();
        int idx;
        bit hit;
        for (int p = 0; p < 2; p++) begin
            idx = int'(bus.rd_addr_in[p*5 +: 5]);
            hit = idx != 0 && bus.commit_en_in && int'(bus.commit_rd_in) == idx &&
                  int'(bus.commit_tag_in) == m_tag[idx];
            chk("rd_busy", 32'(bus.rd_busy_out[p]), (idx == 0 || hit) ? 0 : 32'(m_busy[idx]));
            chk("rd_value", bus.rd_value_out[p*32 +: 32],
                idx == 0 ? 32'h0 : (hit ? bus.commit_value_in : m_val[idx]));
            if (!hit) chk("rd_tag", 32'(bus.rd_reorder_out[p*4 +: 4]), idx == 0 ? 0 : 32'(m_tag[idx]));
        end
        chk("ckpt_full", 32'(bus.ckpt_full_out), 32'(m_count == 4));
        chk("save_id", 32'(bus.ckpt_save_id_out), 32'(m_tail));
    endtask

    task automatic idle();
        rst_n_in = 1'b1;
        bus.rdy_in = 1'b1; bus.rd_addr_in = '0;
        bus.rename_en_in = 1'b0; bus.rename_rd_in = '0; bus.rename_reorder_in = '0;
        bus.ckpt_save_en_in = 1'b0; bus.ckpt_restore_en_in = 1'b0; bus.ckpt_restore_id_in = '0;
        bus.ckpt_release_en_in = 1'b0;
        bus.commit_en_in = 1'b0; bus.commit_rd_in = '0; bus.commit_value_in = '0; bus.commit_tag_in = '0;
        bus.flush_in = 1'b0;
    endtask

    task automatic step();
        #1;
        cmp_model();
        @(posedge clk_in);
        model_tick();
        @(negedge clk_in);
        idle();
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        step();
    endtask

    task automatic ren(input int r, input int t);
        bus.rename_en_in = 1'b1; bus.rename_rd_in = 5'(r); bus.rename_reorder_in = 4'(t);
    endtask

    task automatic cmt(input int r, input int t, input logic [31:0] v);
        bus.commit_en_in = 1'b1; bus.commit_rd_in = 5'(r); bus.commit_tag_in = 4'(t); bus.commit_value_in = v;
    endtask

    initial begin
        idle();
        rst_n_in = 1'b0;
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        idle();

        // Reset state
        bus.rd_addr_in = {5'd0, 5'd5};
        #1;
        chk("rst_full", 32'(bus.ckpt_full_out), 0);
        chk("rst_save_id", 32'(bus.ckpt_save_id_out), 0);
        chk("rst_busy", 32'(bus.rd_busy_out[0]), 0);
        chk("rst_value", bus.rd_value_out[31:0], 0);
        step();

        // Commit bypass on a same-cycle read
        ren(5, 3); step();
        cmt(5, 3, 32'h11); bus.rd_addr_in = {5'd0, 5'd5};
        #1;
        chk("byp_busy", 32'(bus.rd_busy_out[0]), 0);
        chk("byp_value", bus.rd_value_out[31:0], 32'h11);
        step();
        bus.rd_addr_in = {5'd0, 5'd5};
        #1;
        chk("post_byp_busy", 32'(bus.rd_busy_out[0]), 0);
        chk("post_byp_tag", 32'(bus.rd_reorder_out[3:0]), 0);
        step();

        // Stale commit leaves newer rename in place
        ren(5, 3); step();
        ren(5, 6); step();
        cmt(5, 3, 32'h7); step();
        bus.rd_addr_in = {5'd5, 5'd0};
        #1;
        chk("stale_value", bus.rd_value_out[63:32], 32'h7);
        chk("stale_busy", 32'(bus.rd_busy_out[1]), 1);
        chk("stale_tag", 32'(bus.rd_reorder_out[7:4]), 6);
        step();

        // Save / restore of a renamed register
        do_reset();
        ren(1, 2); step();
        bus.ckpt_save_en_in = 1'b1; step();
        ren(1, 5); step();
        bus.ckpt_restore_en_in = 1'b1; bus.ckpt_restore_id_in = 2'd0; step();
        bus.rd_addr_in = {5'd0, 5'd1};
        #1;
        chk("restore_busy", 32'(bus.rd_busy_out[0]), 1);
        chk("restore_tag", 32'(bus.rd_reorder_out[3:0]), 2);
        chk("restore_save_id", 32'(bus.ckpt_save_id_out), 0);
        step();

        // Fill, overflow, release, restore truncation
        do_reset();
        for (int i = 0; i < 4; i++) begin bus.ckpt_save_en_in = 1'b1; step(); end
        #1; chk("full_set", 32'(bus.ckpt_full_out), 1);
        bus.ckpt_save_en_in = 1'b1; step();
        #1; chk("full_hold_id", 32'(bus.ckpt_save_id_out), 0);
        bus.ckpt_release_en_in = 1'b1; step();
        #1; chk("full_clr", 32'(bus.ckpt_full_out), 0);
        bus.ckpt_restore_en_in = 1'b1; bus.ckpt_restore_id_in = 2'd2; step();
        #1; chk("trunc_id", 32'(bus.ckpt_save_id_out), 2);
        for (int i = 0; i < 3; i++) begin bus.ckpt_save_en_in = 1'b1; step(); end
        #1; chk("trunc_refill", 32'(bus.ckpt_full_out), 1);
        step();

        // Commit clears matching snapshot entries
        do_reset();
        ren(1, 2); step();
        bus.ckpt_save_en_in = 1'b1; step();
        cmt(1, 2, 32'h9); step();
        bus.ckpt_restore_en_in = 1'b1; bus.ckpt_restore_id_in = 2'd0; step();
        bus.rd_addr_in = {5'd1, 5'd1};
        #1;
        chk("snap_clr_busy", 32'(bus.rd_busy_out[0]), 0);
        chk("snap_clr_value", bus.rd_value_out[31:0], 32'h9);
        step();

        // x0, flush, out-of-window restore, reset under stall
        ren(0, 4); cmt(0, 4, 32'hdead); step();
        bus.rd_addr_in = {5'd0, 5'd0};
        #1;
        chk("x0_busy", 32'(bus.rd_busy_out), 0);
        chk("x0_value", bus.rd_value_out[31:0], 0);
        step();
        for (int i = 0; i < 3; i++) begin bus.ckpt_save_en_in = 1'b1; ren(7, i + 1); step(); end
        bus.flush_in = 1'b1; cmt(9, 1, 32'h55); step();
        bus.rd_addr_in = {5'd9, 5'd7};
        #1;
        chk("flush_id", 32'(bus.ckpt_save_id_out), 0);
        chk("flush_busy", 32'(bus.rd_busy_out[0]), 0);
        chk("flush_value", bus.rd_value_out[63:32], 32'h55);
        step();
        ren(3, 7); step();
        bus.ckpt_restore_en_in = 1'b1; bus.ckpt_restore_id_in = 2'd1; step();
        bus.rd_addr_in = {5'd0, 5'd3};
        #1; chk("oow_tag", 32'(bus.rd_reorder_out[3:0]), 7);
        step();
        bus.rdy_in = 1'b0; rst_n_in = 1'b0; step();
        bus.rdy_in = 1'b0; ren(4, 3); bus.rd_addr_in = {5'd4, 5'd9}; step();
        bus.rd_addr_in = {5'd4, 5'd9};
        #1;
        chk("rstrdy_value", bus.rd_value_out[31:0], 0);
        chk("rstrdy_busy", 32'(bus.rd_busy_out[1]), 0);
        step();

        // Random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int cr;
            rst_n_in = ($urandom_range(0, 199) != 0);
            bus.rdy_in = ($urandom_range(0, 9) != 0);
            bus.rd_addr_in = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            if ($urandom_range(0, 1) == 1) ren($urandom_range(0, 7), $urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) begin
                cr = $urandom_range(0, 7);
                cmt(cr, (m_tag[cr] != 0 && $urandom_range(0, 3) != 0) ? m_tag[cr] : $urandom_range(1, 15), $urandom);
            end
            bus.ckpt_save_en_in    = ($urandom_range(0, 9) < 3);
            bus.ckpt_release_en_in = ($urandom_range(0, 9) < 2);
            bus.ckpt_restore_en_in = ($urandom_range(0, 11) == 0);
            bus.ckpt_restore_id_in = 2'($urandom_range(0, 3));
            bus.flush_in           = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
